countdown_ctrl: RTL and testbench
=================================

# countdown_ctrl

Control FSM for the BCD countdown timer chain (mod10 seconds-ones, mod6 seconds-tens, mod10 minutes). It takes keypad digits and start/stop/clear commands and holds the entered preset. It then drives the chain's active-low load and clear lines and gates the 1 Hz tick into the chain's enable. When the chain reports zero, it raises a timed alarm. It sits between the user-input decoder and the counter chain, and it is the only block driving `loadn`, `clrn` and `enable`.

## Interface
- `ALARM_TICKS`, default 3: number of tick pulses the `alarm` output stays high in DONE (1..15).
- `clock` in 1: sole clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `digit` in 4: keypad BCD digit.
- `digit_valid` in 1: one-cycle strobe qualifying `digit`.
- `start` in 1: one-cycle strobe, start or resume.
- `stop` in 1: one-cycle strobe, pause or abort.
- `clear` in 1: one-cycle strobe, abort and clear from any state.
- `tick` in 1: one-cycle 1 Hz strobe.
- `zero` in 1: counter chain reports all digits zero.
- `data` out 12: preset to the chain, `{min_ones, sec_tens, sec_ones}`.
- `loadn` out 1: active-low parallel load to the chain.
- `clrn` out 1: active-low clear to the chain.
- `enable` out 1: count-down enable pulse to the chain.
- `alarm` out 1: countdown finished.
- `err` out 1: one-cycle pulse when a start is rejected.

## Operation
- States: IDLE, ENTRY, LOAD, RUN, PAUSE, DONE.
- Command priority, same cycle: `reset` > `clear` > `stop` > `start` > `digit_valid`. Lower-priority strobes in that cycle are dropped.
- IDLE/ENTRY, `digit_valid` with `digit` ≤ 9:
  - buffer shifts left one digit: sec_ones←digit, sec_tens←old sec_ones, min_ones←old sec_tens; the old min_ones is discarded.
  - state → ENTRY.
- `digit` > 9 is ignored in all states. `digit_valid` in LOAD, RUN, PAUSE or DONE is ignored.
- ENTRY, `start`:
  - if sec_tens > 5 or the buffer is all zero: pulse `err`, stay in ENTRY.
  - otherwise → LOAD.
- `start` in IDLE is ignored.
- LOAD: `loadn`=0 for exactly one cycle, then → RUN.
- RUN:
  - each `tick` produces one `enable` pulse.
  - `zero`=1 in any RUN cycle except the first → DONE.
  - `stop` → PAUSE.
- PAUSE:
  - `enable` held 0; ticks are discarded.
  - `start` → RUN, without reload.
  - `stop` → IDLE with clear.
- DONE:
  - `alarm`=1 and `enable`=0.
  - an internal 4-bit counter counts ticks; on reaching `ALARM_TICKS` → IDLE with clear.
  - `stop`/`start` → IDLE with clear immediately.
- "IDLE with clear" (also caused by `clear` from any state):
  - buffer ← 0 and `clrn`=0 for one cycle.
  - `alarm` drops in the same cycle as `clrn` goes low.
- The buffer is retained through RUN/PAUSE/DONE, but cleared on every return to IDLE.

## Timing
- All outputs are registered, so every output change appears on the edge after its cause.
- While `reset` is high:
  - state=IDLE, buffer=0, `data`=0.
  - `loadn`=1, `clrn`=0, `enable`=0, `alarm`=0, `err`=0.
- `clrn` returns to 1 on the first edge with `reset` low.
- Digit strobe at edge N → `data` updated after edge N+1.
- Accepted `start` at N → `loadn`=0 during cycle N+1 only. RUN begins at N+2.
- `tick` sampled high in RUN at edge N → `enable`=1 during cycle N+1 only.
- A `tick` coinciding with the `stop` that enters PAUSE produces no `enable` pulse.
- `zero` is sampled once per cycle with no synchronizer; the chain is on the same clock.
- A `tick` and `zero` in the same RUN cycle: DONE wins and no `enable` pulse is issued.
- Reset mid-RUN aborts at once and the chain is cleared.

## Structure
- Package `countdown_pkg`:
  - state enum `state_t`.
  - `DIGIT_W`=4, `NUM_DIGITS`=3.
  - constants `MAX_TENS`=5 and `MAX_DIGIT`=9.
- Sub-module `digit_buffer`:
  - 3×4-bit shift register with shift-enable and synchronous clear.
  - outputs the 12-bit preset and its `tens_ok`/`nonzero` flags.
- The FSM and alarm tick counter are in `countdown_ctrl`.

## Test plan
- Enter 1, 4, 5; `start`:
  - `data`=12'h145.
  - one-cycle `loadn`=0, then five `tick`s give five `enable` pulses.
  - hold `zero`=1 → `alarm`=1 for 3 ticks, then `clrn` pulse and IDLE.
- Enter 0, 7, 0 (sec_tens=7); `start`:
  - `err` pulse, no `loadn`, stays in ENTRY.
  - `digit`=12 is ignored (`data` unchanged).
- In RUN, `stop`:
  - ticks produce no `enable`.
  - `start` resumes enables without a `loadn` pulse.
  - second `stop` from PAUSE → `clrn`=0 for one cycle, `data`=0.
- Same cycle: `clear`, `start` and `digit_valid` in ENTRY → IDLE, `clrn` pulse, buffer 0, no `loadn`.
- `reset` asserted mid-RUN for 2 cycles:
  - all outputs at reset values during it, with `clrn`=0 throughout.
  - `clrn`=1 on the cycle after release.
- Enter 1, 2, 3, 4: `data`=12'h234 (oldest digit dropped).

Source files
------------

// File: rtl/countdown_pkg.sv
`default_nettype none
// ============================================================================
// Module  : countdown_pkg
// Purpose : Shared types and constants for the BCD countdown controller.
// Revision: 1.0 - initial release
// ============================================================================
package countdown_pkg;

  localparam int DIGIT_W    = 4;
  localparam int NUM_DIGITS = 3;
  localparam int DATA_W     = DIGIT_W * NUM_DIGITS;

  // Largest legal seconds-tens digit and largest legal BCD digit
  localparam logic [DIGIT_W-1:0] MAX_TENS  = 4'd5;
  localparam logic [DIGIT_W-1:0] MAX_DIGIT = 4'd9;

  // Canonical state encoding for the controller FSM
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ENTRY = 3'd1,
    ST_LOAD  = 3'd2,
    ST_RUN   = 3'd3,
    ST_PAUSE = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  // True when a keypad code is a real BCD digit
  function automatic logic digit_ok(input logic [DIGIT_W-1:0] d);
    return (d <= MAX_DIGIT);
  endfunction

endpackage
`default_nettype wire

// File: rtl/digit_buffer.sv
`default_nettype none
// ============================================================================
// Module  : digit_buffer
// Purpose : Three-digit BCD shift register holding the keypad preset, with
//           validity flags for the start check.
// Revision: 1.0 - initial release
// ============================================================================
module digit_buffer
  import countdown_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                i_shift,
  input  logic                i_clr,
  input  logic [DIGIT_W-1:0]  i_digit,
  output logic [DATA_W-1:0]   o_data,
  output logic                o_tens_ok,
  output logic                o_nonzero
);

  // Layout {min_ones, sec_tens, sec_ones}
  logic [DATA_W-1:0] r_buf;

  // New digit enters at sec_ones; the oldest (min_ones) falls off the top
  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_buf <= '0;
    end else if (i_shift) begin
      r_buf <= {r_buf[DATA_W-DIGIT_W-1:0], i_digit};
    end
  end

  assign o_data    = r_buf;
  assign o_tens_ok = (r_buf[2*DIGIT_W-1:DIGIT_W] <= MAX_TENS);
  assign o_nonzero = |r_buf;

endmodule
`default_nettype wire

// File: rtl/countdown_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : countdown_ctrl
// Purpose : Control FSM for the BCD countdown chain: keypad preset entry,
//           load/clear/enable generation and timed alarm.
// Revision: 1.0 - initial release
// ============================================================================
module countdown_ctrl
  import countdown_pkg::*;
#(
  parameter int ALARM_TICKS = 3
)
(
  input  logic               clock,
  input  logic               reset,
  input  logic [DIGIT_W-1:0] digit,
  input  logic               digit_valid,
  input  logic               start,
  input  logic               stop,
  input  logic               clear,
  input  logic               tick,
  input  logic               zero,
  output logic [DATA_W-1:0]  data,
  output logic               loadn,
  output logic               clrn,
  output logic               enable,
  output logic               alarm,
  output logic               err
);

  localparam logic [2:0] c_st_idle  = ST_IDLE;
  localparam logic [2:0] c_st_entry = ST_ENTRY;
  localparam logic [2:0] c_st_load  = ST_LOAD;
  localparam logic [2:0] c_st_run   = ST_RUN;
  localparam logic [2:0] c_st_pause = ST_PAUSE;
  localparam logic [2:0] c_st_done  = ST_DONE;
  localparam logic [3:0] c_alarm_last = 4'(ALARM_TICKS - 1);

  logic [2:0]        r_state;
  logic [2:0]        w_next;
  logic [3:0]        r_alarm_cnt;
  logic              r_run_first;
  logic [DATA_W-1:0] r_data;
  logic              r_loadn, r_clrn, r_enable, r_alarm, r_err;

  logic              w_shift, w_to_idle, w_err, w_pulse_en;
  logic              w_cmd_stop, w_cmd_start, w_cmd_digit;
  logic [DATA_W-1:0] w_buf_data;
  logic              w_tens_ok, w_nonzero;

  // Only the highest-priority strobe of a cycle is acted on
  assign w_cmd_stop  = stop & ~clear;
  assign w_cmd_start = start & ~clear & ~stop;
  assign w_cmd_digit = digit_valid & ~clear & ~stop & ~start & digit_ok(digit);

  digit_buffer u_buf (
    .clk       (clock),
    .rst       (reset),
    .i_shift   (w_shift),
    .i_clr     (w_to_idle),
    .i_digit   (digit),
    .o_data    (w_buf_data),
    .o_tens_ok (w_tens_ok),
    .o_nonzero (w_nonzero)
  );

  // Next-state decode; "to idle" always implies a chain clear and buffer wipe
  always_comb begin
    w_next     = r_state;
    w_shift    = 1'b0;
    w_to_idle  = 1'b0;
    w_err      = 1'b0;
    w_pulse_en = 1'b0;
    if (clear) begin
      w_to_idle = 1'b1;
    end else begin
      case (r_state)
        c_st_idle: begin
          if (w_cmd_digit) begin
            w_shift = 1'b1;
            w_next  = c_st_entry;
          end
        end
        c_st_entry: begin
          if (w_cmd_start) begin
            if (!w_tens_ok || !w_nonzero) w_err  = 1'b1;
            else                          w_next = c_st_load;
          end else if (w_cmd_digit) begin
            w_shift = 1'b1;
          end
        end
        c_st_load: w_next = c_st_run;
        c_st_run: begin
          // zero is ignored in the first RUN cycle while the chain settles
          if (w_cmd_stop)                w_next = c_st_pause;
          else if (zero && !r_run_first) w_next = c_st_done;
          else if (tick)                 w_pulse_en = 1'b1;
        end
        c_st_pause: begin
          if (w_cmd_stop)       w_to_idle = 1'b1;
          else if (w_cmd_start) w_next    = c_st_run;
        end
        c_st_done: begin
          if (w_cmd_stop || w_cmd_start)          w_to_idle = 1'b1;
          else if (tick && r_alarm_cnt == c_alarm_last) w_to_idle = 1'b1;
        end
        default: w_to_idle = 1'b1;
      endcase
    end
    if (w_to_idle) w_next = c_st_idle;
  end

  // State, alarm tick counter and registered outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= c_st_idle;
      r_alarm_cnt <= '0;
      r_run_first <= 1'b0;
      r_data      <= '0;
      r_loadn     <= 1'b1;
      r_clrn      <= 1'b0;
      r_enable    <= 1'b0;
      r_alarm     <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_run_first <= (w_next == c_st_run) && (r_state != c_st_run);
      if (r_state != c_st_done)  r_alarm_cnt <= '0;
      else if (tick)             r_alarm_cnt <= r_alarm_cnt + 4'd1;
      r_data      <= w_buf_data;
      r_loadn     <= (w_next != c_st_load);
      r_clrn      <= ~w_to_idle;
      r_enable    <= w_pulse_en;
      r_alarm     <= (w_next == c_st_done);
      r_err       <= w_err;
    end
  end

  assign data   = r_data;
  assign loadn  = r_loadn;
  assign clrn   = r_clrn;
  assign enable = r_enable;
  assign alarm  = r_alarm;
  assign err    = r_err;

endmodule
`default_nettype wire

// File: tb/tb_countdown_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_countdown_ctrl
// Purpose : Directed self-checking bench for countdown_ctrl.
// Revision: 1.0 - initial release
// ============================================================================
module tb_countdown_ctrl;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  digit = 4'd0;
  logic        digit_valid = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        clear = 1'b0;
  logic        tick = 1'b0;
  logic        zero = 1'b0;
  logic [11:0] data;
  logic        loadn, clrn, enable, alarm, err;

  typedef struct packed {
    logic [11:0] data;
    logic        loadn;
    logic        clrn;
    logic        enable;
    logic        alarm;
    logic        err;
  } out_t;

  out_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clock = ~clock;

  countdown_ctrl #(.ALARM_TICKS(3)) dut (
    .clock       (clock),
    .reset       (reset),
    .digit       (digit),
    .digit_valid (digit_valid),
    .start       (start),
    .stop        (stop),
    .clear       (clear),
    .tick        (tick),
    .zero        (zero),
    .data        (data),
    .loadn       (loadn),
    .clrn        (clrn),
    .enable      (enable),
    .alarm       (alarm),
    .err         (err)
  );

  // Push the outputs expected after the next edge, clock, then pop and compare
  task automatic step(input string tag, input logic [11:0] d, input logic l,
                      input logic c, input logic e, input logic a, input logic r);
    out_t exp_v;
    out_t got;
    exp_q.push_back(out_t'{d, l, c, e, a, r});
    @(posedge clock);
    #1;
    got   = out_t'({data, loadn, clrn, enable, alarm, err});
    exp_v = exp_q.pop_front();
    checks++;
    assert (got === exp_v) else begin
      errors++;
      $error("FAIL %s: got data=%h loadn=%b clrn=%b en=%b alarm=%b err=%b, expected data=%h loadn=%b clrn=%b en=%b alarm=%b err=%b",
             tag, got.data, got.loadn, got.clrn, got.enable, got.alarm, got.err,
             exp_v.data, exp_v.loadn, exp_v.clrn, exp_v.enable, exp_v.alarm, exp_v.err);
    end
    digit_valid = 1'b0;
    start       = 1'b0;
    stop        = 1'b0;
    clear       = 1'b0;
    tick        = 1'b0;
  endtask

  // Keypad entry in IDLE/ENTRY: data shows the buffer one edge late
  task automatic key(input logic [3:0] d, input string tag, input logic [11:0] exp_d);
    digit_valid = 1'b1;
    digit       = d;
    step(tag, exp_d, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    // Reset values, clrn released on first edge with reset low
    step("rst_a", 12'h000, 1, 0, 0, 0, 0);
    step("rst_b", 12'h000, 1, 0, 0, 0, 0);
    reset = 1'b0;
    step("rst_rel", 12'h000, 1, 1, 0, 0, 0);

    // All-zero preset is rejected
    key(4'd0, "k0", 12'h000);
    start = 1'b1;
    step("err_zero", 12'h000, 1, 1, 0, 0, 1);
    step("err_gone", 12'h000, 1, 1, 0, 0, 0);

    // Four digits: oldest dropped
    key(4'd1, "k1", 12'h000);
    key(4'd2, "k2", 12'h001);
    key(4'd3, "k3", 12'h012);
    key(4'd4, "k4", 12'h123);
    step("d234", 12'h234, 1, 1, 0, 0, 0);

    // clear beats start and digit in the same cycle
    clear = 1'b1; start = 1'b1; digit_valid = 1'b1; digit = 4'd3;
    step("clr_a", 12'h234, 1, 0, 0, 0, 0);
    step("clr_b", 12'h000, 1, 1, 0, 0, 0);
    start = 1'b1;
    step("idle_start", 12'h000, 1, 1, 0, 0, 0);

    // 1,4,5 -> run five ticks -> alarm for three ticks
    key(4'd1, "k1b", 12'h000);
    key(4'd4, "k4b", 12'h001);
    key(4'd5, "k5b", 12'h014);
    step("d145", 12'h145, 1, 1, 0, 0, 0);
    start = 1'b1;
    step("load", 12'h145, 0, 1, 0, 0, 0);
    step("run", 12'h145, 1, 1, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      tick = 1'b1;
      step("en_pulse", 12'h145, 1, 1, 1, 0, 0);
      step("en_gap", 12'h145, 1, 1, 0, 0, 0);
    end
    zero = 1'b1;
    tick = 1'b1;
    step("done_no_en", 12'h145, 1, 1, 0, 1, 0);
    for (int i = 0; i < 2; i++) begin
      tick = 1'b1;
      step("al_tick", 12'h145, 1, 1, 0, 1, 0);
      step("al_hold", 12'h145, 1, 1, 0, 1, 0);
    end
    tick = 1'b1;
    step("al_end", 12'h145, 1, 0, 0, 0, 0);
    zero = 1'b0;
    step("al_clr", 12'h000, 1, 1, 0, 0, 0);

    // 0,7,0: sec_tens 7 rejected; digit 12 ignored
    key(4'd0, "k0c", 12'h000);
    key(4'd7, "k7c", 12'h000);
    key(4'd0, "k0d", 12'h007);
    step("d070", 12'h070, 1, 1, 0, 0, 0);
    start = 1'b1;
    step("err_tens", 12'h070, 1, 1, 0, 0, 1);
    digit_valid = 1'b1; digit = 4'd12;
    step("bad_dig_a", 12'h070, 1, 1, 0, 0, 0);
    step("bad_dig_b", 12'h070, 1, 1, 0, 0, 0);
    clear = 1'b1;
    step("clr2_a", 12'h070, 1, 0, 0, 0, 0);
    step("clr2_b", 12'h000, 1, 1, 0, 0, 0);

    // Pause / resume / abort
    key(4'd2, "k2e", 12'h000);
    key(4'd0, "k0e", 12'h002);
    step("d020", 12'h020, 1, 1, 0, 0, 0);
    start = 1'b1;
    step("load2", 12'h020, 0, 1, 0, 0, 0);
    step("run2", 12'h020, 1, 1, 0, 0, 0);
    zero = 1'b1; tick = 1'b1;
    step("first_zero", 12'h020, 1, 1, 1, 0, 0);
    zero = 1'b0;
    step("run2_gap", 12'h020, 1, 1, 0, 0, 0);
    stop = 1'b1; tick = 1'b1;
    step("pause", 12'h020, 1, 1, 0, 0, 0);
    tick = 1'b1;
    step("pause_tick", 12'h020, 1, 1, 0, 0, 0);
    start = 1'b1;
    step("resume", 12'h020, 1, 1, 0, 0, 0);
    tick = 1'b1;
    step("resume_en", 12'h020, 1, 1, 1, 0, 0);
    step("resume_gap", 12'h020, 1, 1, 0, 0, 0);
    stop = 1'b1;
    step("pause2", 12'h020, 1, 1, 0, 0, 0);
    stop = 1'b1;
    step("abort_a", 12'h020, 1, 0, 0, 0, 0);
    step("abort_b", 12'h000, 1, 1, 0, 0, 0);

    // Reset mid-RUN
    key(4'd3, "k3f", 12'h000);
    key(4'd0, "k0f", 12'h003);
    step("d030", 12'h030, 1, 1, 0, 0, 0);
    start = 1'b1;
    step("load3", 12'h030, 0, 1, 0, 0, 0);
    step("run3", 12'h030, 1, 1, 0, 0, 0);
    tick = 1'b1; reset = 1'b1;
    step("rst_run_a", 12'h000, 1, 0, 0, 0, 0);
    tick = 1'b1;
    step("rst_run_b", 12'h000, 1, 0, 0, 0, 0);
    reset = 1'b0;
    step("rst_run_rel", 12'h000, 1, 1, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
